wave_fetch_scheduler: RTL and testbench

Upstream neighbour of the per-wavefront instruction queues in the wavepool. Holds one fetch PC per wavefront slot and picks one eligible wavefront per request, round-robin, to send to the fetch unit. For each accepted request it reserves a queue slot by pulsing that wave's virtual-tail increment. It routes fetch returns into the matching queue as a write. Branch redirects flush the queue, and stale returns are discarded using a per-wave epoch bit.

---
 rtl/wave_fetch_scheduler.sv | 179 +++++++++++++++++
 tb/tb_wave_fetch_scheduler.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_fetch_scheduler.sv
// Per-wavefront fetch PC holder and round-robin fetch requester for the wavepool.
// Reserves instruction-queue slots on accept, routes epoch-checked returns, flushes on taken branches.
module wave_fetch_scheduler #(
  parameter int NUM_WF = 40,
  parameter int WID_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              new_wf_valid,
  input  logic [WID_W-1:0]  new_wf_id,
  input  logic [31:0]       new_wf_pc,
  input  logic              halt_valid,
  input  logic [WID_W-1:0]  halt_wfid,
  input  logic              br_wait_valid,
  input  logic [WID_W-1:0]  br_wait_wfid,
  input  logic              br_valid,
  input  logic [WID_W-1:0]  br_wfid,
  input  logic              br_taken,
  input  logic [31:0]       br_target,
  input  logic [NUM_WF-1:0] stop_fetch_vec,
  output logic              fetch_valid,
  output logic [WID_W-1:0]  fetch_wfid,
  output logic [31:0]       fetch_pc,
  output logic              fetch_epoch,
  input  logic              fetch_ack,
  input  logic              ret_valid,
  input  logic [WID_W-1:0]  ret_wfid,
  input  logic              ret_epoch,
  input  logic [31:0]       ret_pc,
  input  logic [31:0]       ret_instr,
  output logic [NUM_WF-1:0] q_vtail_incr_vec,
  output logic [NUM_WF-1:0] q_wr_vec,
  output logic [NUM_WF-1:0] q_reset_vec,
  output logic [63:0]       q_wr_data
);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  localparam logic [NUM_WF-1:0] SLOT0 = 1;

  state_t            state, state_nxt;
  logic [NUM_WF-1:0] active, br_pending, epoch;
  logic [31:0]       pc [NUM_WF];
  logic [WID_W-1:0]  rr_ptr;

  logic [NUM_WF-1:0] new_oh, halt_oh, wait_oh, brv_oh, eligible;
  logic              grant_found;
  logic [WID_W-1:0]  grant_id;

  logic              ack_hit, redirect_hit, ack_ok, withdraw, wr_hit;
  logic [WID_W-1:0]  ptr_after_ack;

  logic              fetch_valid_nxt;
  logic [WID_W-1:0]  fetch_wfid_nxt;
  logic [31:0]       fetch_pc_nxt;
  logic              fetch_epoch_nxt;

  // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    new_oh  = '0;
    halt_oh = '0;
    wait_oh = '0;
    brv_oh  = '0;
    if (new_wf_valid)  new_oh[new_wf_id]     = 1'b1;
    if (halt_valid)    halt_oh[halt_wfid]    = 1'b1;
    if (br_wait_valid) wait_oh[br_wait_wfid] = 1'b1;
    if (br_valid)      brv_oh[br_wfid]       = 1'b1;
  end

  // Slots touched by any event this cycle sit out one grant so the presented PC/epoch is never stale.
  assign eligible = active & ~stop_fetch_vec & ~br_pending
                  & ~(new_oh | halt_oh | wait_oh | brv_oh);

  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int i = 0; i < NUM_WF; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_WF) idx = idx - NUM_WF;
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant_id    = WID_W'(idx);
      end
    end
  end

  assign ack_hit       = (state == S_REQ) && fetch_ack;
  assign redirect_hit  = br_valid && br_taken && (br_wfid == fetch_wfid);
  assign ack_ok        = ack_hit && !redirect_hit;
  assign withdraw      = (state == S_REQ) && !fetch_ack &&
                         ((halt_valid    && (halt_wfid    == fetch_wfid)) ||
                          (br_valid      && (br_wfid      == fetch_wfid)) ||
                          (br_wait_valid && (br_wait_wfid == fetch_wfid)));
  assign ptr_after_ack = (fetch_wfid == WID_W'(NUM_WF - 1)) ? '0 : fetch_wfid + 1'b1;

  assign wr_hit = ret_valid && (ret_wfid < WID_W'(NUM_WF)) &&
                  active[ret_wfid] && (ret_epoch == epoch[ret_wfid]);

  always_comb begin
    state_nxt       = state;
    fetch_valid_nxt = fetch_valid;
    fetch_wfid_nxt  = fetch_wfid;
    fetch_pc_nxt    = fetch_pc;
    fetch_epoch_nxt = fetch_epoch;
    case (state)
      S_IDLE: begin
        if (grant_found) begin
          state_nxt       = S_REQ;
          fetch_valid_nxt = 1'b1;
          fetch_wfid_nxt  = grant_id;
          fetch_pc_nxt    = pc[grant_id];
          fetch_epoch_nxt = epoch[grant_id];
        end
      end
      S_REQ: begin
        if (fetch_ack || withdraw) begin
          state_nxt       = S_IDLE;
          fetch_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous and active-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      fetch_valid      <= 1'b0;
      fetch_wfid       <= '0;
      fetch_pc         <= '0;
      fetch_epoch      <= 1'b0;
      rr_ptr           <= '0;
      active           <= '0;
      br_pending       <= '0;
      epoch            <= '0;
      q_vtail_incr_vec <= '0;
      q_wr_vec         <= '0;
      q_reset_vec      <= '0;
      q_wr_data        <= '0;
    end else begin
      state            <= state_nxt;
      fetch_valid      <= fetch_valid_nxt;
      fetch_wfid       <= fetch_wfid_nxt;
      fetch_pc         <= fetch_pc_nxt;
      fetch_epoch      <= fetch_epoch_nxt;
      q_vtail_incr_vec <= ack_ok ? (SLOT0 << fetch_wfid) : '0;
      q_reset_vec      <= (br_valid && br_taken) ? brv_oh : '0;
      q_wr_vec         <= wr_hit ? (SLOT0 << ret_wfid) : '0;
      if (wr_hit) q_wr_data <= {ret_pc, ret_instr};
      if (ack_hit) rr_ptr <= ptr_after_ack;

      for (int i = 0; i < NUM_WF; i++) begin
        if (new_oh[i]) begin
          active[i]     <= 1'b1;
          br_pending[i] <= 1'b0;
        end else begin
          if (halt_oh[i]) active[i] <= 1'b0;
          // A fresh branch seen in the same cycle an older one resolves keeps the wave blocked.
          if (wait_oh[i])     br_pending[i] <= 1'b1;
          else if (brv_oh[i]) br_pending[i] <= 1'b0;
        end
        if (brv_oh[i] && br_taken) epoch[i] <= ~epoch[i];
      end
    end
  end

  // NOTE: the PC file has no reset; a slot's PC is always loaded by new_wf before the slot can be granted.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_WF; i++) begin
      if (new_oh[i])                                     pc[i] <= new_wf_pc;
      else if (brv_oh[i] && br_taken)                    pc[i] <= br_target;
      else if (ack_ok && (fetch_wfid == WID_W'(i)))      pc[i] <= pc[i] + 32'd4;
    end
  end

endmodule

// File: tb/tb_wave_fetch_scheduler.sv
// Directed bench for wave_fetch_scheduler: grant order, PC stepping, stop/branch handling, return routing.
module tb_wave_fetch_scheduler;

  localparam int NUM_WF = 40;

  logic              clk = 1'b0;
  logic              rst;
  logic              new_wf_valid;
  logic [5:0]        new_wf_id;
  logic [31:0]       new_wf_pc;
  logic              halt_valid;
  logic [5:0]        halt_wfid;
  logic              br_wait_valid;
  logic [5:0]        br_wait_wfid;
  logic              br_valid;
  logic [5:0]        br_wfid;
  logic              br_taken;
  logic [31:0]       br_target;
  logic [NUM_WF-1:0] stop_fetch_vec;
  logic              fetch_valid;
  logic [5:0]        fetch_wfid;
  logic [31:0]       fetch_pc;
  logic              fetch_epoch;
  logic              fetch_ack;
  logic              ret_valid;
  logic [5:0]        ret_wfid;
  logic              ret_epoch;
  logic [31:0]       ret_pc;
  logic [31:0]       ret_instr;
  logic [NUM_WF-1:0] q_vtail_incr_vec;
  logic [NUM_WF-1:0] q_wr_vec;
  logic [NUM_WF-1:0] q_reset_vec;
  logic [63:0]       q_wr_data;

  int checks = 0;
  int errors = 0;

  wave_fetch_scheduler dut (
    .clk              (clk),
    .rst              (rst),
    .new_wf_valid     (new_wf_valid),
    .new_wf_id        (new_wf_id),
    .new_wf_pc        (new_wf_pc),
    .halt_valid       (halt_valid),
    .halt_wfid        (halt_wfid),
    .br_wait_valid    (br_wait_valid),
    .br_wait_wfid     (br_wait_wfid),
    .br_valid         (br_valid),
    .br_wfid          (br_wfid),
    .br_taken         (br_taken),
    .br_target        (br_target),
    .stop_fetch_vec   (stop_fetch_vec),
    .fetch_valid      (fetch_valid),
    .fetch_wfid       (fetch_wfid),
    .fetch_pc         (fetch_pc),
    .fetch_epoch      (fetch_epoch),
    .fetch_ack        (fetch_ack),
    .ret_valid        (ret_valid),
    .ret_wfid         (ret_wfid),
    .ret_epoch        (ret_epoch),
    .ret_pc           (ret_pc),
    .ret_instr        (ret_instr),
    .q_vtail_incr_vec (q_vtail_incr_vec),
    .q_wr_vec         (q_wr_vec),
    .q_reset_vec      (q_reset_vec),
    .q_wr_data        (q_wr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] oh(input int id);
    logic [63:0] one;
    one = 64'd1;
    return one << id;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    new_wf_valid = 1'b0; new_wf_id = '0; new_wf_pc = '0;
    halt_valid = 1'b0; halt_wfid = '0;
    br_wait_valid = 1'b0; br_wait_wfid = '0;
    br_valid = 1'b0; br_wfid = '0; br_taken = 1'b0; br_target = '0;
    stop_fetch_vec = '0; fetch_ack = 1'b0;
    ret_valid = 1'b0; ret_wfid = '0; ret_epoch = 1'b0; ret_pc = '0; ret_instr = '0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic start_wave(input int id, input logic [31:0] p);
    new_wf_valid = 1'b1; new_wf_id = 6'(id); new_wf_pc = p;
    step();
    new_wf_valid = 1'b0;
  endtask

  task automatic send_ret(input int id, input logic ep, input logic [31:0] p, input logic [31:0] ins);
    ret_valid = 1'b1; ret_wfid = 6'(id); ret_epoch = ep; ret_pc = p; ret_instr = ins;
    step();
    ret_valid = 1'b0;
  endtask

  // Waits (bounded) for a request, then checks its id, pc and epoch.
  task automatic wait_req(input string tag, input int id, input logic [31:0] p, input logic ep);
    int n = 0;
    while (!fetch_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_valid"}, 64'(fetch_valid), 64'd1);
    check({tag, "_wfid"},  64'(fetch_wfid),  64'(id));
    check({tag, "_pc"},    64'(fetch_pc),    64'(p));
    check({tag, "_epoch"}, 64'(fetch_epoch), 64'(ep));
  endtask

  task automatic accept(input string tag, input int id, input logic [31:0] p, input logic ep);
    wait_req(tag, id, p, ep);
    fetch_ack = 1'b1;
    step();
    fetch_ack = 1'b0;
    check({tag, "_vtail"},   64'(q_vtail_incr_vec), oh(id));
    check({tag, "_dropped"}, 64'(fetch_valid),      64'd0);
  endtask

  initial begin
    logic saw;

    // Reset values
    do_reset();
    check("rst_fetch_valid", 64'(fetch_valid), 64'd0);
    check("rst_fetch_wfid",  64'(fetch_wfid),  64'd0);
    check("rst_fetch_pc",    64'(fetch_pc),    64'd0);
    check("rst_fetch_epoch", 64'(fetch_epoch), 64'd0);
    check("rst_vtail",       64'(q_vtail_incr_vec), 64'd0);
    check("rst_wr",          64'(q_wr_vec),    64'd0);
    check("rst_reset",       64'(q_reset_vec), 64'd0);
    check("rst_wr_data",     q_wr_data,        64'd0);

    // Single wave, sequential PCs, then halt withdraws the held request
    start_wave(3, 32'h100);
    accept("w3_a", 3, 32'h100, 1'b0);
    accept("w3_b", 3, 32'h104, 1'b0);
    accept("w3_c", 3, 32'h108, 1'b0);
    wait_req("w3_d", 3, 32'h10C, 1'b0);
    halt_valid = 1'b1; halt_wfid = 6'd3;
    step();
    halt_valid = 1'b0;
    check("halt_withdraw_valid", 64'(fetch_valid),      64'd0);
    check("halt_withdraw_vtail", 64'(q_vtail_incr_vec), 64'd0);
    step(3);
    check("halt_stays_idle", 64'(fetch_valid), 64'd0);

    // Round-robin with wrap past slot 39
    do_reset();
    start_wave(0,  32'h1000);
    start_wave(5,  32'h5000);
    start_wave(39, 32'h3900);
    accept("rr_0",  0,  32'h1000, 1'b0);
    accept("rr_5",  5,  32'h5000, 1'b0);
    accept("rr_39", 39, 32'h3900, 1'b0);
    accept("rr_0b", 0,  32'h1004, 1'b0);

    // stop_fetch masks grant only; a held request survives a later stop
    do_reset();
    stop_fetch_vec = 40'd1 << 5;
    start_wave(5, 32'h5000);
    start_wave(0, 32'h200);
    accept("stop_0a", 0, 32'h200, 1'b0);
    accept("stop_0b", 0, 32'h204, 1'b0);
    stop_fetch_vec = '0;
    wait_req("unstop_5", 5, 32'h5000, 1'b0);
    stop_fetch_vec = 40'd1 << 5;
    step(2);
    check("stop_hold_valid", 64'(fetch_valid), 64'd1);
    check("stop_hold_wfid",  64'(fetch_wfid),  64'd5);
    fetch_ack = 1'b1;
    step();
    fetch_ack = 1'b0;
    check("stop_hold_vtail", 64'(q_vtail_incr_vec), oh(5));
    stop_fetch_vec = '0;

    // Branch wait then taken redirect on wave 2
    do_reset();
    start_wave(2, 32'h300);
    br_wait_valid = 1'b1; br_wait_wfid = 6'd2;
    step();
    br_wait_valid = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (fetch_valid) saw = 1'b1;
      step();
    end
    check("brwait_no_req", 64'(saw), 64'd0);
    br_valid = 1'b1; br_wfid = 6'd2; br_taken = 1'b1; br_target = 32'h400;
    step();
    br_valid = 1'b0; br_taken = 1'b0;
    check("br_qreset", 64'(q_reset_vec),      oh(2));
    check("br_vtail",  64'(q_vtail_incr_vec), 64'd0);
    send_ret(2, 1'b0, 32'h300, 32'h1111_2222);
    check("br_stale_ret", 64'(q_wr_vec),    64'd0);
    check("br_qreset_end", 64'(q_reset_vec), 64'd0);
    wait_req("br_target", 2, 32'h400, 1'b1);

    // Return routing on wave 7
    do_reset();
    start_wave(7, 32'h700);
    send_ret(7, 1'b0, 32'h20, 32'hDEADBEEF);
    check("ret7_wr",   64'(q_wr_vec), oh(7));
    check("ret7_data", q_wr_data,     64'h0000_0020_DEAD_BEEF);
    send_ret(8, 1'b0, 32'h24, 32'h0);
    check("ret_inactive", 64'(q_wr_vec), 64'd0);
    send_ret(7, 1'b1, 32'h28, 32'h0);
    check("ret_bad_epoch", 64'(q_wr_vec), 64'd0);

    // Taken redirect together with ack on the presented wave: flush wins
    wait_req("redir_req", 7, 32'h700, 1'b0);
    fetch_ack = 1'b1;
    br_valid = 1'b1; br_wfid = 6'd7; br_taken = 1'b1; br_target = 32'h800;
    step();
    fetch_ack = 1'b0; br_valid = 1'b0; br_taken = 1'b0;
    check("redir_vtail",  64'(q_vtail_incr_vec), 64'd0);
    check("redir_qreset", 64'(q_reset_vec),      oh(7));
    check("redir_valid",  64'(fetch_valid),      64'd0);
    send_ret(7, 1'b0, 32'h700, 32'hCAFE_F00D);
    check("redir_stale_ret", 64'(q_wr_vec), 64'd0);
    wait_req("redir_next", 7, 32'h800, 1'b1);

    // Reset while a request is held, with ack in the same cycle
    rst = 1'b1;
    fetch_ack = 1'b1;
    step();
    fetch_ack = 1'b0;
    check("midrst_valid", 64'(fetch_valid),      64'd0);
    check("midrst_vtail", 64'(q_vtail_incr_vec), 64'd0);
    rst = 1'b0;
    step(3);
    check("midrst_idle", 64'(fetch_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
